step_pulse_shaper: RTL
======================

STEP_PULSE_SHAPER -- requirements
Module: step_pulse_shaper

Interface
REQ-001 SHALL have parameter MOTORS, default 4: number of step/dir channels.
REQ-002 SHALL have parameter PULSE_W, default 8: step_out high time in clk cycles, range 1..255.
REQ-003 SHALL have parameter GAP_W, default 8: minimum step_out low time after a pulse, range 1..255.
REQ-004 SHALL have parameter DIR_SETUP, default 16: cycles dir_out is stable before step_out rises after a direction change, range 1..255.
REQ-005 SHALL have parameter DEPTH, default 4: per-channel request FIFO depth, power of two, 2..16.
REQ-006 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-007 SHALL have port aclr, input, 1: reset, asynchronous, active-high.
REQ-008 SHALL have port sclr, input, 1: synchronous clear, active-high.
REQ-009 SHALL have port ena, input, 1: channel enable (driven from motor output-enable).
REQ-010 SHALL have port step_in, input, MOTORS: step requests, one per rising edge.
REQ-011 SHALL have port dir_in, input, MOTORS: direction, sampled with the step_in rising edge.
REQ-012 SHALL have port ovf_clr, input, 1: clears ovf when high.
REQ-013 SHALL have port step_out, output, MOTORS: driver-compliant step pulses, registered.
REQ-014 SHALL have port dir_out, output, MOTORS: driver direction, registered.
REQ-015 SHALL have port busy, output, MOTORS: channel FIFO non-empty or FSM not IDLE.
REQ-016 SHALL have port ovf, output, MOTORS: sticky dropped-request flag.
REQ-017 SHALL have port drop_cnt, output, MOTORS x 8: dropped-request count (see Configuration).

Function
REQ-018 SHALL register step_in per channel and detect a request when step_in=1 and its registered copy=0.
REQ-019 SHALL push {dir_in} into the channel FIFO at the same edge a request is detected, if ena=1.
REQ-020 SHALL drop a request when the FIFO is full and no pop occurs that edge, and set ovf for that channel.
REQ-021 SHALL accept a push on a full FIFO when a pop occurs at the same edge.
REQ-022 SHALL run one FSM per channel with states IDLE, SETUP, PULSE, GAP.
REQ-023 IDLE, FIFO non-empty, popped dir equal to dir_out: SHALL pop, enter PULSE, set step_out=1 at that edge.
REQ-024 IDLE, FIFO non-empty, popped dir different: SHALL pop, load dir_out, enter SETUP, step_out stays 0.
REQ-025 SETUP SHALL last exactly DIR_SETUP cycles, then enter PULSE with step_out=1.
REQ-026 PULSE SHALL last exactly PULSE_W cycles, then enter GAP with step_out=0.
REQ-027 GAP SHALL last exactly GAP_W cycles; at its last cycle, FIFO non-empty, SHALL pop directly as from IDLE, else enter IDLE.
REQ-028 Latency: request detected at edge k, channel IDLE, FIFO empty, same dir: step_out SHALL be high after edge k+1.
REQ-029 Back-to-back same-dir requests SHALL produce step period exactly PULSE_W+GAP_W cycles.
REQ-030 dir_out SHALL change only in transition from IDLE/GAP to SETUP, never during PULSE.
REQ-031 ena=0: SHALL ignore new requests, flush the FIFO, complete any PULSE and GAP in progress, abort SETUP to IDLE.
REQ-032 ovf_clr=1 SHALL clear ovf; a drop at the same edge SHALL win (ovf stays 1).
REQ-033 Channels SHALL be fully independent.

Reset
REQ-034 aclr (async) and sclr (sync) SHALL set: step_out=0, dir_out=0, ovf=0, drop_cnt=0, FIFOs empty, FSMs IDLE, step_in registers 0.
REQ-035 Reset mid-PULSE SHALL drop step_out to 0 immediately (aclr) or at the next edge (sclr).

Configuration
REQ-036 Macro STEP_SHAPER_DROP_CNT_EN defined: drop_cnt SHALL count dropped requests per channel, saturating at 255, cleared by ovf_clr (drop same edge wins, count=1).
REQ-037 Macro undefined: drop_cnt SHALL be constant 0 and no counter logic SHALL be built.

Verification
REQ-038 Single request, dir unchanged, PULSE_W=8, GAP_W=8: step_out high 2nd edge after step_in rise, exactly 8 cycles.
REQ-039 Dir change 0->1, DIR_SETUP=16: dir_out=1 one edge after detection, step_out rises 16 cycles later.
REQ-040 Six requests one cycle apart, DEPTH=4: five pulses out (one popped immediately, four queued) and one dropped, ovf=1, drop_cnt=1 with macro, 0 without.
REQ-041 ena dropped mid-PULSE with 3 queued: current pulse completes full width, no further pulses, busy=0 after GAP.
REQ-042 aclr asserted mid-PULSE: step_out=0 without a clock edge; all FIFOs empty, ovf=0 afterwards.
REQ-043 Continuous same-dir requests every 16 cycles: step period exactly 16 cycles, no drops.

Source files
------------

// File: rtl/step_pulse_shaper.sv
`default_nettype none
// ============================================================================
// Module      : step_pulse_shaper
// Description : Multi-channel step/dir pulse conditioner for stepper drivers.
//               Each channel detects rising edges on step_in, queues the
//               sampled direction in a small FIFO, and replays the requests
//               as driver-compliant pulses. Every pulse has a fixed high time
//               (PULSE_W) and a minimum low time (GAP_W). Whenever the
//               direction changes, dir_out is held stable for DIR_SETUP
//               cycles before the next rising edge on step_out.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters  : MOTORS    - number of step/dir channels
//               PULSE_W   - step_out high time in clk cycles (1..255)
//               GAP_W     - minimum step_out low time (1..255)
//               DIR_SETUP - dir_out to step_out setup time (1..255)
//               DEPTH     - per-channel request FIFO depth (power of 2, 2..16)
// Ports       : clk      in   sole clock, rising edge
//               aclr     in   asynchronous reset, active-high
//               sclr     in   synchronous clear, active-high
//               ena      in   channel enable; low flushes queued requests
//               step_in  in   [MOTORS] step requests, one per rising edge
//               dir_in   in   [MOTORS] direction, sampled with step_in rise
//               ovf_clr  in   clears ovf (and drop_cnt)
//               step_out out  [MOTORS] shaped step pulses (registered)
//               dir_out  out  [MOTORS] driver direction (registered)
//               busy     out  [MOTORS] FIFO non-empty or FSM not idle
//               ovf      out  [MOTORS] sticky dropped-request flag
//               drop_cnt out  [MOTORS*8] per-channel dropped-request count
// Build macro : STEP_SHAPER_DROP_CNT_EN - when defined, drop_cnt holds a
//               saturating per-channel drop counter; otherwise it is tied
//               to zero and no counter logic is built.
// ============================================================================
module step_pulse_shaper #(
    parameter int MOTORS    = 4,
    parameter int PULSE_W   = 8,
    parameter int GAP_W     = 8,
    parameter int DIR_SETUP = 16,
    parameter int DEPTH     = 4
) (
    input  logic                  clk,
    input  logic                  aclr,
    input  logic                  sclr,
    input  logic                  ena,
    input  logic [MOTORS-1:0]     step_in,
    input  logic [MOTORS-1:0]     dir_in,
    input  logic                  ovf_clr,
    output logic [MOTORS-1:0]     step_out,
    output logic [MOTORS-1:0]     dir_out,
    output logic [MOTORS-1:0]     busy,
    output logic [MOTORS-1:0]     ovf,
    output logic [MOTORS*8-1:0]   drop_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_PULSE = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    localparam int              c_aw       = $clog2(DEPTH);
    localparam logic [c_aw:0]   c_full     = (c_aw+1)'(DEPTH);
    localparam logic [c_aw:0]   c_cnt_one  = (c_aw+1)'(1);
    localparam logic [c_aw-1:0] c_ptr_one  = c_aw'(1);
    // Phase counters are loaded with length-1 and the phase ends on zero.
    localparam logic [7:0]      c_pulse_ld = 8'(PULSE_W - 1);
    localparam logic [7:0]      c_gap_ld   = 8'(GAP_W - 1);
    localparam logic [7:0]      c_setup_ld = 8'(DIR_SETUP - 1);

    for (genvar m = 0; m < MOTORS; m++) begin : g_ch
        logic            r_step_q;
        logic [DEPTH-1:0] r_mem;
        logic [c_aw-1:0] r_rd_ptr;
        logic [c_aw-1:0] r_wr_ptr;
        logic [c_aw:0]   r_count;
        state_t          r_state;
        state_t          w_state_nx;
        logic [7:0]      r_cnt;
        logic [7:0]      w_cnt_nx;
        logic            r_dir;
        logic            w_dir_nx;
        logic            r_step;
        logic            w_step_nx;
        logic            r_ovf;
        logic            w_req;
        logic            w_empty;
        logic            w_full;
        logic            w_pop;
        logic            w_push;
        logic            w_drop;
        logic            w_pop_dir;

        assign w_req     = step_in[m] & ~r_step_q;
        assign w_empty   = (r_count == '0);
        assign w_full    = (r_count == c_full);
        assign w_pop_dir = r_mem[r_rd_ptr];
        // A pop happens from IDLE, or on the final GAP cycle so that
        // back-to-back requests keep a period of exactly PULSE_W+GAP_W.
        assign w_pop  = ena & ~w_empty &
                        ((r_state == ST_IDLE) |
                         ((r_state == ST_GAP) & (r_cnt == 8'd0)));
        // A pop frees a slot in the same edge, so a full FIFO still accepts.
        assign w_push = ena & w_req & (~w_full | w_pop);
        assign w_drop = ena & w_req & w_full & ~w_pop;

        // Edge detector and request FIFO
        always_ff @(posedge clk or posedge aclr) begin
            if (aclr) begin
                r_step_q <= 1'b0;
                r_mem    <= '0;
                r_rd_ptr <= '0;
                r_wr_ptr <= '0;
                r_count  <= '0;
            end else if (sclr) begin
                r_step_q <= 1'b0;
                r_mem    <= '0;
                r_rd_ptr <= '0;
                r_wr_ptr <= '0;
                r_count  <= '0;
            end else begin
                r_step_q <= step_in[m];
                if (!ena) begin
                    r_rd_ptr <= '0;
                    r_wr_ptr <= '0;
                    r_count  <= '0;
                end else begin
                    if (w_push) begin
                        r_mem[r_wr_ptr] <= dir_in[m];
                        r_wr_ptr        <= r_wr_ptr + c_ptr_one;
                    end
                    if (w_pop) begin
                        r_rd_ptr <= r_rd_ptr + c_ptr_one;
                    end
                    case ({w_push, w_pop})
                        2'b10:   r_count <= r_count + c_cnt_one;
                        2'b01:   r_count <= r_count - c_cnt_one;
                        default: r_count <= r_count;
                    endcase
                end
            end
        end

        // Pulse FSM: state register
        always_ff @(posedge clk or posedge aclr) begin
            if (aclr) begin
                r_state <= ST_IDLE;
                r_cnt   <= '0;
                r_dir   <= 1'b0;
                r_step  <= 1'b0;
            end else if (sclr) begin
                r_state <= ST_IDLE;
                r_cnt   <= '0;
                r_dir   <= 1'b0;
                r_step  <= 1'b0;
            end else begin
                r_state <= w_state_nx;
                r_cnt   <= w_cnt_nx;
                r_dir   <= w_dir_nx;
                r_step  <= w_step_nx;
            end
        end

        // Pulse FSM: next state and registered-output next values
        always_comb begin
            w_state_nx = r_state;
            w_cnt_nx   = r_cnt;
            w_dir_nx   = r_dir;
            w_step_nx  = r_step;
            case (r_state)
                ST_IDLE, ST_GAP: begin
                    if ((r_state == ST_GAP) && (r_cnt != 8'd0)) begin
                        w_cnt_nx = r_cnt - 8'd1;
                    end else if (w_pop) begin
                        if (w_pop_dir == r_dir) begin
                            w_state_nx = ST_PULSE;
                            w_cnt_nx   = c_pulse_ld;
                            w_step_nx  = 1'b1;
                        end else begin
                            // Direction changes only here, while step_out is low.
                            w_state_nx = ST_SETUP;
                            w_cnt_nx   = c_setup_ld;
                            w_dir_nx   = w_pop_dir;
                            w_step_nx  = 1'b0;
                        end
                    end else begin
                        w_state_nx = ST_IDLE;
                        w_cnt_nx   = 8'd0;
                        w_step_nx  = 1'b0;
                    end
                end
                ST_SETUP: begin
                    if (!ena) begin
                        w_state_nx = ST_IDLE;
                        w_cnt_nx   = 8'd0;
                    end else if (r_cnt == 8'd0) begin
                        w_state_nx = ST_PULSE;
                        w_cnt_nx   = c_pulse_ld;
                        w_step_nx  = 1'b1;
                    end else begin
                        w_cnt_nx = r_cnt - 8'd1;
                    end
                end
                ST_PULSE: begin
                    if (r_cnt == 8'd0) begin
                        w_state_nx = ST_GAP;
                        w_cnt_nx   = c_gap_ld;
                        w_step_nx  = 1'b0;
                    end else begin
                        w_cnt_nx = r_cnt - 8'd1;
                    end
                end
                default: begin
                    w_state_nx = ST_IDLE;
                    w_cnt_nx   = 8'd0;
                    w_step_nx  = 1'b0;
                end
            endcase
        end

        // Sticky overflow flag; a drop on the clearing edge takes priority.
        always_ff @(posedge clk or posedge aclr) begin
            if (aclr) begin
                r_ovf <= 1'b0;
            end else if (sclr) begin
                r_ovf <= 1'b0;
            end else if (w_drop) begin
                r_ovf <= 1'b1;
            end else if (ovf_clr) begin
                r_ovf <= 1'b0;
            end
        end

`ifdef STEP_SHAPER_DROP_CNT_EN
        logic [7:0] r_drop_cnt;

        always_ff @(posedge clk or posedge aclr) begin
            if (aclr) begin
                r_drop_cnt <= 8'd0;
            end else if (sclr) begin
                r_drop_cnt <= 8'd0;
            end else if (w_drop) begin
                if (ovf_clr) begin
                    r_drop_cnt <= 8'd1;
                end else if (r_drop_cnt != 8'hFF) begin
                    r_drop_cnt <= r_drop_cnt + 8'd1;
                end
            end else if (ovf_clr) begin
                r_drop_cnt <= 8'd0;
            end
        end

        assign drop_cnt[m*8 +: 8] = r_drop_cnt;
`else
        assign drop_cnt[m*8 +: 8] = 8'd0;
`endif

        assign step_out[m] = r_step;
        assign dir_out[m]  = r_dir;
        assign busy[m]     = ~w_empty | (r_state != ST_IDLE);
        assign ovf[m]      = r_ovf;
    end

endmodule
`default_nettype wire
